// File: rtl/bopit_pkg.sv
// Shared types and constants for the Bop-It round controller.
// The LFSR is a right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
package bopit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HIT   = 3'd3,
    S_MISS  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 land on bits 0,2,3,5 because the register shifts right.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [3:0]        NO_CMD    = 4'b0000;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/bopit_tick_gen.sv
// Millisecond tick prescaler: one-cycle o_tick every TICK_DIV clocks,
// restarted from zero by a synchronous i_clr.
module bopit_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bopit_round_ctrl.sv
// Bop-It round sequencer: issues commands, times the response window, flashes on a miss.
// Define BOPIT_LIVES_EN for three lives per game; without it the first miss ends the game.
module bopit_round_ctrl
  import bopit_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int WINDOW_MS  = 1500,
  parameter int WINDOW_DEC = 50,
  parameter int WINDOW_MIN = 300,
  parameter int FLASH_MS   = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] cmd,
  output logic       flash,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);
  localparam int              TW        = 16;
  localparam int              TW1       = TW + 1;
  localparam logic [TW-1:0]   WIN_INIT  = TW'(WINDOW_MS);
  localparam logic [TW-1:0]   WIN_DEC   = TW'(WINDOW_DEC);
  localparam logic [TW-1:0]   WIN_MIN   = TW'(WINDOW_MIN);
  localparam logic [TW-1:0]   FLASH_LEN = TW'(FLASH_MS);
  localparam logic [TW1-1:0]  WIN_THR   = TW1'(WINDOW_MIN + WINDOW_DEC);

  state_t            r_state, w_next;
  logic [LFSR_W-1:0] r_lfsr;
  logic [3:0]        r_cmd;
  logic [3:0]        w_draw;
  logic [7:0]        r_score;
  logic [TW-1:0]     r_win_len;
  logic [TW-1:0]     r_tmr;
  logic [1:0]        w_lives;
  logic              w_tick, w_clr, w_hit, w_bad, w_tmr_done, w_lives_left, w_start_ok;

  bopit_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  assign w_draw     = 4'b0001 << r_lfsr[1:0];
  assign w_hit      = (btn == r_cmd);
  assign w_bad      = (btn != NO_CMD) && !w_hit;
  assign w_tmr_done = w_tick && (r_tmr <= 16'd1);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_OVER));

`ifdef BOPIT_LIVES_EN
  logic [1:0] r_lives;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lives <= 2'd3;
    end else if (w_start_ok) begin
      r_lives <= 2'd3;
    end else if ((r_state == S_WAIT) && (w_next == S_MISS) && (r_lives != 2'd0)) begin
      r_lives <= r_lives - 2'd1;
    end
  end
  assign w_lives = r_lives;
`else
  assign w_lives = 2'd0;
`endif
  assign w_lives_left = (w_lives != 2'd0);

  // Prescaler restarts on entry to WAIT and MISS so windows and flashes are whole ticks.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER: if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        w_next = S_WAIT;
        w_clr  = 1'b1;
      end
      S_WAIT: begin
        if (w_hit) begin
          w_next = S_HIT;
        end else if (w_bad || w_tmr_done) begin
          w_next = S_MISS;
          w_clr  = 1'b1;
        end
      end
      S_HIT:  w_next = S_ISSUE;
      S_MISS: if (w_tmr_done) w_next = w_lives_left ? S_ISSUE : S_OVER;
      default: w_next = S_IDLE;
    endcase
  end

  // After a hit the next command is drawn during HIT so it is visible while in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_cmd     <= NO_CMD;
      r_score   <= 8'd0;
      r_win_len <= WIN_INIT;
      r_tmr     <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= lfsr_next(r_lfsr);
      unique case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_score   <= 8'd0;
            r_win_len <= WIN_INIT;
          end
        end
        S_ISSUE: begin
          r_tmr <= r_win_len;
          if (r_cmd == NO_CMD) r_cmd <= w_draw;
        end
        S_WAIT: begin
          if (w_next == S_MISS) begin
            r_cmd <= NO_CMD;
            r_tmr <= FLASH_LEN;
          end else if (w_tick) begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
        S_HIT: begin
          r_cmd <= w_draw;
          if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          if ({1'b0, r_win_len} >= WIN_THR) r_win_len <= r_win_len - WIN_DEC;
          else                              r_win_len <= WIN_MIN;
        end
        S_MISS: if (w_tick) r_tmr <= r_tmr - 16'd1;
        default: r_cmd <= NO_CMD;
      endcase
    end
  end

  assign cmd       = r_cmd;
  assign flash     = (r_state == S_MISS);
  assign score     = r_score;
  assign lives     = w_lives;
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// Directed-plus-random bench for bopit_round_ctrl against a game-level reference model.
// Works with and without BOPIT_LIVES_EN.
module tb_bopit_round_ctrl;
  localparam int TD = 4, WMS = 10, WDEC = 3, WMIN = 4, FMS = 5;
`ifdef BOPIT_LIVES_EN
  localparam int LIVES_INIT = 3;
`else
  localparam int LIVES_INIT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] cmd;
  logic       flash;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int m_score, m_win, m_lives;
  logic [3:0] m_cmd;

  bopit_round_ctrl #(
    .TICK_DIV(TD), .WINDOW_MS(WMS), .WINDOW_DEC(WDEC), .WINDOW_MIN(WMIN), .FLASH_MS(FMS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .cmd(cmd),
    .flash(flash), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Number of LFSR advances since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Command implied by the spec LFSR after n advances from the seed.
  function automatic logic [3:0] lfsr_cmd(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < n; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return 4'b0001 << s[1:0];
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Leaves the bench in the first WAIT cycle.
  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cmd_issue_cycle", cmd, 0);
    tick();
    m_score = 0; m_win = WMS; m_lives = LIVES_INIT;
    m_cmd = lfsr_cmd(cyc - 1);
    chk("cmd_after_start", cmd, m_cmd);
    chk("score_cleared", score, 0);
    chk("game_over_low", game_over, 0);
    chk("lives_loaded", lives, LIVES_INIT);
  endtask

  task automatic hit(input int d);
    repeat (d) tick();
    btn = m_cmd;
    tick();
    btn = 4'b0000;
    if (m_score < 255) m_score++;
    m_win = (m_win - WDEC < WMIN) ? WMIN : m_win - WDEC;
    tick();
    m_cmd = lfsr_cmd(cyc - 1);
    chk("cmd_after_hit", cmd, m_cmd);
    chk("score_after_hit", score, m_score);
    tick();
  endtask

  // Called in the first MISS cycle; returns in OVER, or in WAIT when lives remain.
  task automatic resolve_miss();
    int hi;
    if (m_lives > 0) m_lives--;
    chk("lives_on_miss", lives, m_lives);
    chk("cmd_cleared_in_miss", cmd, 0);
    hi = 0;
    while (flash === 1'b1 && hi < 100) begin
      hi++;
      tick();
    end
    chk("flash_len", hi, 4 * FMS);
    chk("game_over_after_flash", game_over, (m_lives == 0));
    chk("score_after_miss", score, m_score);
    if (m_lives > 0) begin
      tick();
      m_cmd = lfsr_cmd(cyc - 1);
      chk("cmd_after_life", cmd, m_cmd);
    end
  endtask

  task automatic timeout(input int pre);
    int k;
    k = pre;
    while (flash !== 1'b1 && k < 4 * m_win + 8) begin
      tick();
      k++;
    end
    chk("window_len", k, 4 * m_win);
    if (flash === 1'b1) resolve_miss();
  endtask

  task automatic bad_press(input int d, input logic [3:0] v);
    repeat (d) tick();
    btn = v;
    tick();
    btn = 4'b0000;
    chk("bad_press_miss", flash, 1);
    if (flash === 1'b1) resolve_miss();
  endtask

  task automatic finish_game();
    for (int g = 0; g < 4; g++)
      if (m_lives > 0) bad_press(0, rot(m_cmd));
    chk("game_over_final", game_over, 1);
  endtask

  initial begin
    int d;
    tick();
    chk("rst_cmd", cmd, 0);
    chk("rst_flash", flash, 0);
    chk("rst_score", score, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_lives", lives, LIVES_INIT);
    tick();
    rst_n = 1'b1;

    btn = 4'b1111;
    tick();
    btn = 4'b0000;
    tick();
    chk("idle_ignores_btn", {game_over, flash, cmd}, 0);

    // No press: full-length window, flash, then over.
    start_game();
    timeout(0);
    finish_game();
    chk("over_score", score, 0);
    btn = 4'b0010;
    tick();
    btn = 4'b0000;
    tick();
    chk("over_ignores_btn", {game_over, cmd}, 5'b10000);

    // Eight hits with the third pressed on the timeout tick; window bottoms out at WMIN.
    start_game();
    for (int i = 0; i < 8; i++) begin
      d = (i == 2) ? 4 * m_win - 1 : int'($urandom_range(0, 4 * m_win - 1));
      hit(d);
    end
    chk("window_floor_model", m_win, WMIN);
    timeout(0);
    finish_game();
    chk("over_score_holds", score, 8);

    start_game();
    hit(int'($urandom_range(0, 19)));
    timeout(0);
    finish_game();

    start_game();
    hit(int'($urandom_range(0, 4 * m_win - 1)));
    hit(int'($urandom_range(0, 4 * m_win - 1)));
    timeout(0);
    finish_game();

    start_game();
    hit(int'($urandom_range(0, 4 * m_win - 1)));
    bad_press(int'($urandom_range(0, 4 * m_win - 2)), m_cmd | rot(m_cmd));
    finish_game();
    chk("multi_bit_score", score, 1);

    start_game();
    bad_press(int'($urandom_range(0, 4 * m_win - 2)), 4'b1111);
    finish_game();
    chk("all_bits_score", score, 0);

    // start while waiting must not restart anything.
    start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_cmd", cmd, m_cmd);
    timeout(1);
    finish_game();

    // Reset in the middle of a flash aborts at once.
    start_game();
    hit(int'($urandom_range(0, 4 * m_win - 1)));
    btn = rot(m_cmd);
    tick();
    btn = 4'b0000;
    chk("flash_before_reset", flash, 1);
    if (m_lives > 0) m_lives--;
    chk("lives_before_reset", lives, m_lives);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("reset_flash_async", flash, 0);
    chk("reset_lives", lives, LIVES_INIT);
    chk("reset_score", score, 0);
    tick();
    chk("reset_flash_edge", {flash, game_over, cmd}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {flash, game_over, cmd}, 0);

    start_game();
    hit(int'($urandom_range(0, 4 * m_win - 1)));
    timeout(0);
    finish_game();
    chk("last_game_score", score, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bopit_round_ctrl.md
BOPIT_ROUND_CTRL -- requirements
Module: bopit_round_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-002 SHALL have parameter WINDOW_MS, default 1500, initial response window in ms.
REQ-003 SHALL have parameter WINDOW_DEC, default 50, window shrink in ms per correct hit.
REQ-004 SHALL have parameter WINDOW_MIN, default 300, window floor in ms.
REQ-005 SHALL have parameter FLASH_MS, default 2000, flash duration in ms after a miss.
REQ-006 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that begins a game.
REQ-009 SHALL have port btn, input, 4, debounced one-cycle press pulses, one bit per action.
REQ-010 SHALL have port cmd, output, 4, one-hot current command; 0 when no command is active.
REQ-011 SHALL have port flash, output, 1, drives the downstream LED blinker enable.
REQ-012 SHALL have port score, output, 8, correct-hit count.
REQ-013 SHALL have port lives, output, 2, remaining lives.
REQ-014 SHALL have port game_over, output, 1, high while in OVER.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, HIT, MISS, OVER.
REQ-016 IDLE: on start go to ISSUE; clear score; window_len = WINDOW_MS.
REQ-017 ISSUE: last one cycle; cmd = 1 << lfsr[1:0]; load window counter = window_len; clear prescaler; go to WAIT.
REQ-018 WAIT: btn == cmd goes to HIT; btn != 0 and btn != cmd (wrong or multiple bits) goes to MISS; window counter reaching 0 on a tick goes to MISS.
REQ-019 SHALL give a matching press priority over a timeout in the same cycle.
REQ-020 HIT: last one cycle; score +1, saturating at 255; window_len = max(window_len - WINDOW_DEC, WINDOW_MIN), no underflow; go to ISSUE.
REQ-021 MISS: cmd = 0; flash = 1 for exactly FLASH_MS ticks; then go to OVER (see REQ-030).
REQ-022 OVER: game_over = 1; score holds; start goes to ISSUE with score cleared and window_len reset.
REQ-023 SHALL ignore start outside IDLE and OVER, and ignore btn outside WAIT.
REQ-024 SHALL use a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle and never reaching zero.
REQ-025 SHALL assert a tick when the prescaler reaches TICK_DIV-1, then wrap the prescaler to 0.
REQ-026 Latency: cmd SHALL be valid 2 cycles after start, and 2 cycles after the matching btn.

Reset
REQ-027 rst_n low SHALL force IDLE, cmd=0, flash=0, score=0, game_over=0, prescaler=0, LFSR=seed.
REQ-028 lives SHALL reset to 3 with BOPIT_LIVES_EN and to 0 without it.
REQ-029 Reset asserted mid-game, including during MISS, SHALL abort immediately with no completion of the flash interval.

Configuration
REQ-030 Macro BOPIT_LIVES_EN defined: IDLE/OVER start loads lives=3; each MISS decrements lives on entry; after the flash, lives>0 goes to ISSUE, otherwise goes to OVER.
REQ-031 Macro BOPIT_LIVES_EN undefined: the first MISS leads to OVER; lives is constant 0.

Structure
REQ-032 Package bopit_pkg SHALL hold the state enum, LFSR width/seed/taps, and the NO_CMD constant (4'b0000).
REQ-033 SHALL instantiate one sub-module, bopit_tick_gen (prescaler, outputs a one-cycle tick, clears on a sync clear input).

Verification (TICK_DIV=4, WINDOW_MS=10, WINDOW_DEC=3, WINDOW_MIN=4, FLASH_MS=5)
REQ-034 Start, then btn=cmd within 5 ticks -> score=1; a new one-hot cmd appears 2 cycles later; next window is 7 ticks.
REQ-035 Eight consecutive hits -> window sequence 10,7,4,4,...; never below 4.
REQ-036 No press -> MISS at tick 10; flash high exactly 20 cycles; then game_over=1 (macro off).
REQ-037 Wrong button, and btn=4'b1111 -> immediate MISS; score unchanged.
REQ-038 Matching btn in the same cycle as the timeout tick -> HIT, score incremented.
REQ-039 With BOPIT_LIVES_EN: three misses -> lives 3,2,1,0; game_over only after the third flash; rst_n low during a flash -> flash=0 on the next edge and lives=3.
